// File: rtl/argmax_scan_ctrl.sv
// Streaming arg-max controller: scans one frame of DEPTH unsigned samples
// through a single strict greater-than comparator and returns the maximum
// together with the index of its first occurrence on a valid/ready port.

// Strict unsigned greater-than comparator shared by the scan datapath.
module compare_great_than #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt_c
);

    assign gt_c = (a > b);

endmodule

module argmax_scan_ctrl #(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_max,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic             gt_c;

    // Single comparator: new sample against the running maximum.
    compare_great_than #(.WIDTH(WIDTH)) u_cmp (
        .a    (i_data),
        .b    (o_max),
        .gt_c (gt_c)
    );

    // Frame sequencing, running max/index tracking and registered handshakes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            o_ready <= 1'b0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_max   <= '0;
            o_idx   <= '0;
        end else if (i_abort) begin
            // Abort wins over everything; the result registers keep whatever they hold.
            state   <= IDLE;
            o_ready <= 1'b0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state   <= SCAN;
                        cnt     <= '0;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (i_valid) begin
                        // First sample seeds unconditionally; ties never update, keeping the lowest index.
                        if (cnt == '0) begin
                            o_max <= i_data;
                            o_idx <= '0;
                        end else if (gt_c) begin
                            o_max <= i_data;
                            o_idx <= cnt;
                        end
                        if (cnt == LAST_IDX) begin
                            state   <= DONE;
                            cnt     <= '0;
                            o_ready <= 1'b0;
                            o_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b0;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_scan_ctrl.sv
// Bench for argmax_scan_ctrl: frame-level reference model plus directed
// frames with literal expectations and a randomized traffic phase.
module tb_argmax_scan_ctrl;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_start = 1'b0;
    logic             i_abort = 1'b0;
    logic             i_valid = 1'b0;
    logic [WIDTH-1:0] i_data = '0;
    logic             i_ready = 1'b0;
    logic             o_ready;
    logic             o_valid;
    logic [WIDTH-1:0] o_max;
    logic [IDX_W-1:0] o_idx;
    logic             o_busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    argmax_scan_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (i_start),
        .i_abort (i_abort),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_max   (o_max),
        .o_idx   (o_idx),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: a frame is a list of accepted samples; the result is
    // the arg-max over that list once it holds DEPTH entries.
    logic [WIDTH-1:0] frame [$];
    bit               m_scan = 1'b0;
    bit               m_done = 1'b0;
    logic [WIDTH-1:0] m_max = '0;
    int               m_idx = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_scan = 1'b0;
            m_done = 1'b0;
            m_max  = '0;
            m_idx  = 0;
            frame.delete();
        end else if (i_abort) begin
            m_scan = 1'b0;
            m_done = 1'b0;
        end else if (m_scan) begin
            if (i_valid) begin
                frame.push_back(i_data);
                if (frame.size() == DEPTH) begin
                    m_max = frame[0];
                    m_idx = 0;
                    for (int i = 1; i < DEPTH; i++) begin
                        if (frame[i] > m_max) begin
                            m_max = frame[i];
                            m_idx = i;
                        end
                    end
                    m_scan = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else if (m_done) begin
            if (i_ready) m_done = 1'b0;
        end else if (i_start) begin
            m_scan = 1'b1;
            frame.delete();
        end
    end

    // Compare DUT outputs to the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(o_ready), 32'(m_scan));
            chk("valid", 32'(o_valid), 32'(m_done));
            chk("busy", 32'(o_busy), 32'(m_scan | m_done));
            if (m_done) begin
                chk("max", 32'(o_max), 32'(m_max));
                chk("idx", 32'(o_idx), 32'(m_idx));
            end
        end
    end

    task automatic start_pulse();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Present one sample (after optional random stall cycles) and wait for its accept edge.
    task automatic feed(input logic [WIDTH-1:0] v, input int stall_pct);
        while ($urandom_range(0, 99) < 32'(stall_pct)) begin
            i_valid = 1'b0;
            i_data  = WIDTH'($urandom);
            @(negedge clk);
        end
        if (!o_ready) begin
            errors++;
            $display("FAIL feed: o_ready=0 while a sample was due at %0t", $time);
        end
        i_valid = 1'b1;
        i_data  = v;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    // Check a finished frame against literal expectations, with optional consumer stall.
    task automatic take_result(input string name, input logic [WIDTH-1:0] exp_max,
                               input int exp_idx, input int hold);
        chk({name, "_latency"}, 32'(o_valid), 32'd1);
        chk({name, "_max"}, 32'(o_max), 32'(exp_max));
        chk({name, "_idx"}, 32'(o_idx), 32'(exp_idx));
        i_ready = 1'b0;
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            chk({name, "_held_valid"}, 32'(o_valid), 32'd1);
            chk({name, "_held_max"}, 32'(o_max), 32'(exp_max));
        end
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        chk({name, "_released"}, 32'(o_valid | o_busy), 32'd0);
    endtask

    task automatic run_frame(input string name, input logic [WIDTH-1:0] s [DEPTH], input int stall_pct,
                             input logic [WIDTH-1:0] exp_max, input int exp_idx, input int hold);
        start_pulse();
        for (int i = 0; i < DEPTH; i++) feed(s[i], stall_pct);
        take_result(name, exp_max, exp_idx, hold);
    endtask

    logic [WIDTH-1:0] f [DEPTH];

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_max", 32'(o_max), 32'd0);
        chk("rst_idx", 32'(o_idx), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        f = '{16'd3, 16'd9, 16'd2, 16'd9, 16'd7, 16'd1, 16'd0, 16'd5};
        run_frame("basic", f, 0, 16'd9, 1, 0);

        f = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF};
        run_frame("last_slot", f, 0, 16'hFFFF, 7, 0);

        f = '{default: 16'h1234};
        run_frame("all_equal", f, 0, 16'h1234, 0, 0);

        f = '{16'd100, 16'd99, 16'd98, 16'd97, 16'd96, 16'd95, 16'd94, 16'd93};
        run_frame("valid_gaps", f, 50, 16'd100, 0, 5);

        // Abort after four samples; the sample offered with abort must not count.
        f = '{16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 16'd6};
        start_pulse();
        for (int i = 0; i < 4; i++) feed(16'd500, 0);
        i_abort = 1'b1;
        i_valid = 1'b1;
        i_data  = 16'hFFFF;
        @(negedge clk);
        i_abort = 1'b0;
        i_valid = 1'b0;
        chk("abort_idle", 32'(o_busy | o_ready | o_valid), 32'd0);
        run_frame("after_abort", f, 0, 16'd6, 7, 0);

        // Spurious start in the middle of a scan must not restart the frame.
        f = '{16'd10, 16'd20, 16'd30, 16'd5, 16'd1, 16'd2, 16'd3, 16'd4};
        start_pulse();
        for (int i = 0; i < 3; i++) feed(f[i], 0);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int i = 3; i < DEPTH; i++) feed(f[i], 0);
        take_result("spurious_start", 16'd30, 2, 0);

        // Asynchronous reset between edges after three samples.
        start_pulse();
        for (int i = 0; i < 3; i++) feed(16'd77, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", 32'(o_ready), 32'd0);
        chk("async_rst_busy", 32'(o_busy), 32'd0);
        chk("async_rst_max", 32'(o_max), 32'd0);
        chk("async_rst_idx", 32'(o_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        f = '{16'd8, 16'd1, 16'd8, 16'd2, 16'd11, 16'd3, 16'd11, 16'd0};
        run_frame("after_reset", f, 20, 16'd11, 4, 2);

        // Random traffic on every input, checked only by the model.
        for (int c = 0; c < 3000; c++) begin
            i_start = ($urandom_range(0, 99) < 20);
            i_valid = ($urandom_range(0, 99) < 70);
            i_data  = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(0, 7)) : WIDTH'($urandom);
            i_ready = ($urandom_range(0, 99) < 40);
            i_abort = ($urandom_range(0, 999) < 15);
            @(negedge clk);
        end
        i_start = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        @(negedge clk);
        chk("final_idle", 32'(o_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/argmax_scan_ctrl.md
Name: argmax_scan_ctrl

Overview:
- Sequential controller that streams one frame of DEPTH unsigned samples through a single shared strict greater-than comparator (compare_great_than, WIDTH bits).
- Tracks the running maximum and the index of its first occurrence.
- Presents {max, index} on a valid/ready result port.
- Sits between a sample source (e.g. FIR/FFT magnitude output) and peak-detect/decision logic in the DSP datapath.

Parameters:
- WIDTH, 16, sample bit width; also the comparator width.
- DEPTH, 8, samples per frame, minimum 2.
- IDX_W, $clog2(DEPTH), index width, derived and not overridden.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- i_abort  input  1  synchronous abort; returns to IDLE from any state.
- i_valid  input  1  sample valid.
- i_data  input  WIDTH  sample, unsigned.
- o_ready  output  1  sample accepted when i_valid & o_ready.
- o_valid  output  1  result valid.
- i_ready  input  1  result consumer ready.
- o_max  output  WIDTH  frame maximum.
- o_idx  output  IDX_W  index (0..DEPTH-1) of the first occurrence of o_max.
- o_busy  output  1  high in SCAN or DONE.

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE; o_ready=0, o_valid=0, o_busy=0, o_max=0, o_idx=0; sample counter=0.
- States:
  - IDLE: o_ready=0. i_start=1 -> SCAN, counter cleared.
  - SCAN: o_ready=1, o_busy=1. Each accepted sample with counter value c:
    - c==0: max<=i_data, idx<=0 unconditionally.
    - c>0: if comparator gt(i_data, max)=1 then max<=i_data, idx<=c; else hold.
    - Counter increments by 1 per accepted sample.
    - When the sample with c==DEPTH-1 is accepted -> DONE next cycle.
  - DONE: o_valid=1, o_ready=0; o_max/o_idx stable. o_valid & i_ready -> IDLE next cycle, o_valid drops.
- Comparator: strict unsigned greater-than, combinational, one instance only. Equal values never update, so ties keep the lowest index.
- Latency: o_valid rises on the cycle after the last sample is accepted. Minimum frame time is DEPTH+2 cycles from i_start to the first possible IDLE.
- Backpressure: i_valid=0 cycles in SCAN stall the counter, with no state change. i_ready=0 in DONE holds the result indefinitely.
- o_max/o_idx hold their last result in IDLE and are overwritten only by the first sample of a new frame. They update in SCAN (intermediate values) but are meaningful only while o_valid=1.
- i_start outside IDLE: ignored, no restart.
- i_abort=1: next state IDLE regardless of other inputs. i_abort has priority over i_start and the handshakes. o_valid/o_ready drop next cycle; o_max/o_idx are left as-is. A sample presented in the same cycle as i_abort is not counted.
- Async reset mid-frame: immediate return to the reset values above.
- Counter: width IDX_W. Never wraps past DEPTH-1, because the transition to DONE is taken on the last sample.

Test Plan:
- Basic, DEPTH=8: start, samples 3,9,2,9,7,1,0,5 -> o_valid one cycle after the 8th accept; o_max=9, o_idx=1 (tie keeps first).
- Max at last slot: samples 0,0,0,0,0,0,0,0xFFFF -> o_max=0xFFFF, o_idx=7. All-equal 0x1234 x8 -> o_max=0x1234, o_idx=0.
- Backpressure:
  - i_valid toggled randomly during the frame of descending samples 100..93 -> result 100/0, counter unaffected by idle cycles.
  - i_ready held low 5 cycles in DONE -> o_valid, o_max and o_idx stable throughout; IDLE the cycle after the handshake.
- Abort and spurious start:
  - i_abort after 4 samples, then a new start with 4,4,4,4,4,4,4,6 -> o_max=6, o_idx=7; no residue from the aborted frame.
  - i_start pulsed during SCAN -> ignored, counter unchanged.
- Reset: assert i_rst_n=0 asynchronously (between edges) after 3 samples -> all outputs 0 immediately. After release, start and a full frame produce a correct result.
